// File: rtl/matrix_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// matrix_mac_sequencer_if
//
// Request/response bus between the MAC sequencer and the matrix operand store.
// The sequencer drives an index triple (i, j, k) with ena; the store answers
// with A[i][k] and B[k][j] registered one cycle after the request.
//
// Signals:
//   i, j, k  index request (row of A / column of B / inner index)
//   ena      request valid
//   Aik      operand A[i][k], valid the cycle after the request
//   Bkj      operand B[k][j], valid the cycle after the request
//
// Modports:
//   master  sequencer side (drives indices, receives operands)
//   slave   operand store side
// ---------------------------------------------------------------------------
interface matrix_mac_sequencer_if #(
  parameter int unsigned WIDTH_BIT = 8
) ();

  logic [WIDTH_BIT-1:0] i;
  logic [WIDTH_BIT-1:0] j;
  logic [WIDTH_BIT-1:0] k;
  logic                 ena;
  logic [WIDTH_BIT-1:0] Aik;
  logic [WIDTH_BIT-1:0] Bkj;

  modport master (
    output i,
    output j,
    output k,
    output ena,
    input  Aik,
    input  Bkj
  );

  modport slave (
    input  i,
    input  j,
    input  k,
    input  ena,
    output Aik,
    output Bkj
  );

endinterface

// File: rtl/matrix_mac_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_mac_sequencer
//
// Walks every (i, j, k) index triple of C = A x B, one operand request per
// cycle, multiplies the returned A[i][k] * B[k][j] and accumulates over k.
// Each finished C[i][j] is written into a result register array that holds
// its contents between runs.
//
// Ports:
//   clock    rising-edge clock
//   nreset   asynchronous active-low reset
//   start    request a full multiply (sampled only while idle)
//   op       operand bus (master): i/j/k/ena out, Aik/Bkj in
//   MatrixC  result array [AROWS][BCOLUMNS] x ACC_WIDTH
//   busy     multiply in progress (request and drain cycles)
//   done     single-cycle completion pulse
//
// Timing (start sampled at edge E0, N = AROWS*BCOLUMNS*ACOLUMNS):
//   requests visible in cycles 1..N, busy in cycles 1..N+1, done in N+2.
// ---------------------------------------------------------------------------
module matrix_mac_sequencer #(
  parameter int unsigned AROWS     = 2,
  parameter int unsigned ACOLUMNS  = 2,
  parameter int unsigned BCOLUMNS  = 2,
  parameter int unsigned WIDTH_BIT = 8,
  parameter int unsigned ACC_WIDTH = 18
) (
  input  logic                                           clock,
  input  logic                                           nreset,
  input  logic                                           start,
  matrix_mac_sequencer_if.master                         op,
  output logic [AROWS-1:0][BCOLUMNS-1:0][ACC_WIDTH-1:0]  MatrixC,
  output logic                                           busy,
  output logic                                           done
);

  localparam int unsigned ProdWidth = 2 * WIDTH_BIT;

  localparam logic [WIDTH_BIT-1:0] ILast = WIDTH_BIT'(AROWS - 1);
  localparam logic [WIDTH_BIT-1:0] JLast = WIDTH_BIT'(BCOLUMNS - 1);
  localparam logic [WIDTH_BIT-1:0] KLast = WIDTH_BIT'(ACOLUMNS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // -------------------------------------------------------------------------
  // Request sequencer
  // -------------------------------------------------------------------------
  state_e               state_q;
  logic [WIDTH_BIT-1:0] idx_i_q;
  logic [WIDTH_BIT-1:0] idx_j_q;
  logic [WIDTH_BIT-1:0] idx_k_q;
  logic                 ena_q;
  logic                 busy_q;
  logic                 done_q;

  logic k_wrap;
  logic j_wrap;
  logic i_wrap;

  assign k_wrap = (idx_k_q == KLast);
  assign j_wrap = (idx_j_q == JLast);
  assign i_wrap = (idx_i_q == ILast);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      idx_i_q <= '0;
      idx_j_q <= '0;
      idx_k_q <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StIssue;
            idx_i_q <= '0;
            idx_j_q <= '0;
            idx_k_q <= '0;
            ena_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        StIssue: begin
          if (k_wrap && j_wrap && i_wrap) begin
            // Final triple is on the bus this cycle; keep indices frozen.
            state_q <= StDrain;
            ena_q   <= 1'b0;
          end else if (!k_wrap) begin
            idx_k_q <= idx_k_q + 1'b1;
          end else begin
            idx_k_q <= '0;
            if (!j_wrap) begin
              idx_j_q <= idx_j_q + 1'b1;
            end else begin
              idx_j_q <= '0;
              idx_i_q <= idx_i_q + 1'b1;
            end
          end
        end

        // Operands for the last request return here.
        StDrain: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end

        // start is deliberately not looked at here: no back-to-back queueing.
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          ena_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op.i  = idx_i_q;
  assign op.j  = idx_j_q;
  assign op.k  = idx_k_q;
  assign op.ena = ena_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // -------------------------------------------------------------------------
  // Return pipeline: request attributes delayed by one cycle to line up with
  // the registered operands coming back from the store.
  // -------------------------------------------------------------------------
  logic                 v1_q;
  logic                 first1_q;
  logic                 last1_q;
  logic [WIDTH_BIT-1:0] i1_q;
  logic [WIDTH_BIT-1:0] j1_q;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ProdWidth-1:0] product;
  logic [ACC_WIDTH-1:0] sum;

  logic [AROWS-1:0][BCOLUMNS-1:0][ACC_WIDTH-1:0] c_q;

  always_comb begin
    product = ProdWidth'(op.Aik) * ProdWidth'(op.Bkj);
    // First term of a dot product restarts the accumulator; the sum wraps.
    sum     = (first1_q ? '0 : acc_q) + ACC_WIDTH'(product);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      i1_q     <= '0;
      j1_q     <= '0;
      acc_q    <= '0;
      c_q      <= '0;
    end else begin
      v1_q     <= ena_q;
      first1_q <= (idx_k_q == '0);
      last1_q  <= k_wrap;
      i1_q     <= idx_i_q;
      j1_q     <= idx_j_q;
      if (v1_q) begin
        acc_q <= sum;
        if (last1_q) begin
          for (int unsigned r = 0; r < AROWS; r++) begin
            for (int unsigned c = 0; c < BCOLUMNS; c++) begin
              if ((i1_q == WIDTH_BIT'(r)) && (j1_q == WIDTH_BIT'(c))) begin
                c_q[r][c] <= sum;
              end
            end
          end
        end
      end
    end
  end

  assign MatrixC = c_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
module tb_matrix_mac_sequencer;

  localparam int AR = 2;
  localparam int AC = 2;
  localparam int BC = 2;
  localparam int W  = 8;
  localparam int N  = AR * AC * BC;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  logic start  = 1'b0;

  logic busy18, done18, busy16, done16;
  logic [AR-1:0][BC-1:0][17:0] c18;
  logic [AR-1:0][BC-1:0][15:0] c16;

  logic [W-1:0] a_mat [AR][AC];
  logic [W-1:0] b_mat [AC][BC];

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  matrix_mac_sequencer_if #(.WIDTH_BIT(W)) bus18 ();
  matrix_mac_sequencer_if #(.WIDTH_BIT(W)) bus16 ();

  matrix_mac_sequencer #(
    .AROWS(AR), .ACOLUMNS(AC), .BCOLUMNS(BC), .WIDTH_BIT(W), .ACC_WIDTH(18)
  ) dut18 (
    .clock(clock), .nreset(nreset), .start(start), .op(bus18),
    .MatrixC(c18), .busy(busy18), .done(done18)
  );

  matrix_mac_sequencer #(
    .AROWS(AR), .ACOLUMNS(AC), .BCOLUMNS(BC), .WIDTH_BIT(W), .ACC_WIDTH(16)
  ) dut16 (
    .clock(clock), .nreset(nreset), .start(start), .op(bus16),
    .MatrixC(c16), .busy(busy16), .done(done16)
  );

  always #5 clock = ~clock;

  // Operand store: registered read, one cycle after the request.
  always @(posedge clock) begin
    bus18.Aik <= a_mat[int'(bus18.i) % AR][int'(bus18.k) % AC];
    bus18.Bkj <= b_mat[int'(bus18.k) % AC][int'(bus18.j) % BC];
    bus16.Aik <= a_mat[int'(bus16.i) % AR][int'(bus16.k) % AC];
    bus16.Bkj <= b_mat[int'(bus16.k) % AC][int'(bus16.j) % BC];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: cyc is the cycle number within a run (0 = idle).
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int exp_i = 0, exp_j = 0, exp_k = 0;
  int exp_c [AR][BC];

  always @(posedge clock or negedge nreset) begin
    int r, e, row, col, dot;
    if (!nreset) begin
      cyc = 0; exp_i = 0; exp_j = 0; exp_k = 0;
      for (int a = 0; a < AR; a++) for (int b = 0; b < BC; b++) exp_c[a][b] = 0;
    end else begin
      if (cyc == 0) cyc = start ? 1 : 0;
      else if (cyc == N + 2) cyc = 0;
      else cyc++;
      if (cyc >= 1 && cyc <= N) begin
        r = cyc - 1;
        exp_i = r / (BC * AC);
        exp_j = (r / AC) % BC;
        exp_k = r % AC;
      end
      // Element e becomes visible in cycle AC*(e+1)+2.
      if (cyc >= AC + 2 && (cyc - 2) % AC == 0) begin
        e = (cyc - 2) / AC - 1;
        row = e / BC;
        col = e % BC;
        dot = 0;
        for (int t = 0; t < AC; t++) dot += int'(a_mat[row][t]) * int'(b_mat[t][col]);
        exp_c[row][col] = dot;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("ena18", bus18.ena, (cyc >= 1 && cyc <= N));
      check("busy18", busy18, (cyc >= 1 && cyc <= N + 1));
      check("done18", done18, (cyc == N + 2));
      check("i18", bus18.i, exp_i);
      check("j18", bus18.j, exp_j);
      check("k18", bus18.k, exp_k);
      check("ena16", bus16.ena, (cyc >= 1 && cyc <= N));
      check("busy16", busy16, (cyc >= 1 && cyc <= N + 1));
      check("done16", done16, (cyc == N + 2));
      check("i16", bus16.i, exp_i);
      check("j16", bus16.j, exp_j);
      check("k16", bus16.k, exp_k);
      for (int r = 0; r < AR; r++) begin
        for (int c = 0; c < BC; c++) begin
          check($sformatf("c18[%0d][%0d]", r, c), c18[r][c], exp_c[r][c] % (1 << 18));
          check($sformatf("c16[%0d][%0d]", r, c), c16[r][c], exp_c[r][c] % (1 << 16));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  int ena_cnt, done_cnt, first_done, busy_cnt, busy_first, busy_last, run2_start;
  int seq [$];

  // Caller is at a negedge while idle. Records DUT behaviour for ncyc cycles.
  task automatic run_record(input int drop_at, input int ncyc);
    bit prev_ena;
    ena_cnt = 0; done_cnt = 0; first_done = -1; busy_cnt = 0;
    busy_first = -1; busy_last = -1; run2_start = -1; prev_ena = 1'b0;
    seq.delete();
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      if (c == drop_at) start = 1'b0;
      if (bus18.ena) begin
        ena_cnt++;
        seq.push_back(int'(bus18.i) * 100 + int'(bus18.j) * 10 + int'(bus18.k));
        if (!prev_ena && c > 1) run2_start = c;
      end
      prev_ena = bus18.ena;
      if (done18) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
      if (busy18) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
    end
  endtask

  task automatic run_wait(input string tag);
    int n;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done18 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, done18, 1);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"}, bus18.ena, 0);
    check({tag, "_busy"}, busy18, 0);
    check({tag, "_done"}, done18, 0);
    check({tag, "_ijk"}, {bus18.i, bus18.j, bus18.k}, 0);
    check({tag, "_c18"}, c18, 0);
    check({tag, "_c16"}, c16, 0);
  endtask

  int exp_seq [8] = '{0, 1, 10, 11, 100, 101, 110, 111};
  int exp_basic [4] = '{19, 22, 43, 50};

  task automatic check_basic(input string tag);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("%s_c18_%0d", tag, e), c18[e / 2][e % 2], exp_basic[e]);
    end
  endtask

  initial begin
    int n;
    for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) a_mat[r][c] = '0;
    for (int r = 0; r < AC; r++) for (int c = 0; c < BC; c++) b_mat[r][c] = '0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
    check_all_zero("por");

    // Basic 2x2 run with cycle-level recording.
    a_mat = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    b_mat = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    run_record(1, 11);
    check("basic_ena_cnt", ena_cnt, 8);
    check("basic_seq_len", seq.size(), 8);
    for (int t = 0; t < 8 && t < seq.size(); t++) check($sformatf("seq%0d", t), seq[t], exp_seq[t]);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_cyc", first_done, 10);
    check("basic_busy_cnt", busy_cnt, 9);
    check("basic_busy_first", busy_first, 1);
    check("basic_busy_last", busy_last, 9);
    check_basic("basic");
    check("model_c00", exp_c[0][0], 19);
    check("model_c11", exp_c[1][1], 50);

    // Identity rerun: no residue from the previous accumulation.
    a_mat = '{'{8'd1, 8'd0}, '{8'd0, 8'd1}};
    b_mat = '{'{8'd9, 8'd8}, '{8'd7, 8'd6}};
    run_wait("ident");
    check("ident_c00", c18[0][0], 9);
    check("ident_c01", c18[0][1], 8);
    check("ident_c10", c18[1][0], 7);
    check("ident_c11", c18[1][1], 6);

    // Max operands: exact in 18 bits, wraps in 16 bits.
    a_mat = '{'{8'd255, 8'd255}, '{8'd255, 8'd255}};
    b_mat = '{'{8'd255, 8'd255}, '{8'd255, 8'd255}};
    run_wait("max");
    for (int e = 0; e < 4; e++) begin
      check($sformatf("max_c18_%0d", e), c18[e / 2][e % 2], 130050);
      check($sformatf("max_c16_%0d", e), c16[e / 2][e % 2], 64514);
    end
    check("model_wrap16", exp_c[1][0] % 65536, 64514);

    // start held high: second run starts only after the idle cycle following done.
    a_mat = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    b_mat = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    run_record(12, 24);
    check("hold_done_cnt", done_cnt, 2);
    check("hold_first_done", first_done, 10);
    check("hold_run2_start", run2_start, 12);
    check("hold_ena_cnt", ena_cnt, 16);
    check_basic("hold");

    // Reset mid-ISSUE aborts the run and clears everything asynchronously.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #1 nreset = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clock);
    #2 nreset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (done18) done_cnt++;
      if (busy18) busy_cnt++;
    end
    check("post_rst_done", done_cnt, 0);
    check("post_rst_busy", busy_cnt, 0);

    // Randomized runs with start wiggled while busy and during done.
    for (int run = 0; run < 8; run++) begin
      for (int r = 0; r < AR; r++) for (int c = 0; c < AC; c++) a_mat[r][c] = W'($urandom_range(0, 255));
      for (int r = 0; r < AC; r++) for (int c = 0; c < BC; c++) b_mat[r][c] = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      start = 1'b1;
      n = 0;
      do begin
        @(negedge clock);
        n++;
        if ((cyc >= 1 && cyc <= N) || cyc == N + 2) start = 1'($urandom_range(0, 1));
        else start = 1'b0;
      end while (cyc != 0 && n < 100);
      check($sformatf("rand%0d_finished", run), (n < 100), 1);
    end

    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
